tag_array_ctrl: RTL and testbench

- Port master for the 4-way, 64-set, 22-bit-per-way `tag_array` SRAM wrapper. It drives the RW0 single-port interface and reads its registered rdata.
- Provides lookup with tag compare and victim choice, way-masked tag writes (refill / state update), and a full-array invalidate sweep on reset and on flush.
- Sits between the L1 cache control pipeline and `tag_array`.

---
 rtl/tag_array_ctrl_pkg.sv | 26 ++
 rtl/tag_victim_sel.sv | 20 ++
 rtl/tag_array_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_tag_array_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_array_ctrl_pkg.sv
// Shared definitions for the tag_array port master: geometry, command codes,
// entry bit positions and controller state encodings.
package tag_array_ctrl_pkg;

    localparam int NSETS = 64;
    localparam int NWAYS = 4;
    localparam int TAGW  = 20;
    localparam int IDXW  = 6;
    localparam int ENTW  = TAGW + 2;

    localparam int VALID_BIT = 21;
    localparam int DIRTY_BIT = 20;

    localparam logic [1:0] CMD_LOOKUP = 2'd0;
    localparam logic [1:0] CMD_WRITE  = 2'd1;
    localparam logic [1:0] CMD_INVAL  = 2'd2;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic logic [ENTW-1:0] make_entry(input logic dirty, input logic [TAGW-1:0] tag);
        return {1'b1, dirty, tag};
    endfunction

endpackage

// File: rtl/tag_victim_sel.sv
// Replacement way choice: lowest-numbered invalid way, otherwise the
// round-robin pointer.
module tag_victim_sel
    import tag_array_ctrl_pkg::*;
(
    input  logic [NWAYS-1:0] valid,
    input  logic [1:0]       rr_cnt,
    output logic [1:0]       victim_way
);

    always_comb begin
        victim_way = rr_cnt;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim_way = 2'(w);
            end
        end
    end

endmodule

// File: rtl/tag_array_ctrl.sv
// Port master for the 4-way tag_array SRAM: lookup with hit/victim report,
// way-masked writes, set invalidate and a whole-array clear sweep.
module tag_array_ctrl
    import tag_array_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_cmd,
    input  logic [IDXW-1:0] req_idx,
    input  logic [TAGW-1:0] req_tag,
    input  logic            req_dirty,
    input  logic [NWAYS-1:0] req_way_mask,
    output logic            resp_valid,
    output logic            resp_hit,
    output logic [NWAYS-1:0] resp_hit_way,
    output logic [1:0]      resp_victim_way,
    output logic            resp_victim_valid,
    output logic            resp_victim_dirty,
    output logic [TAGW-1:0] resp_victim_tag,
    input  logic            flush_req,
    output logic            flush_busy,
    output logic [IDXW-1:0] RW0_addr,
    output logic            RW0_en,
    output logic            RW0_wmode,
    output logic [ENTW-1:0] RW0_wdata_0,
    output logic [ENTW-1:0] RW0_wdata_1,
    output logic [ENTW-1:0] RW0_wdata_2,
    output logic [ENTW-1:0] RW0_wdata_3,
    output logic            RW0_wmask_0,
    output logic            RW0_wmask_1,
    output logic            RW0_wmask_2,
    output logic            RW0_wmask_3,
    input  logic [ENTW-1:0] RW0_rdata_0,
    input  logic [ENTW-1:0] RW0_rdata_1,
    input  logic [ENTW-1:0] RW0_rdata_2,
    input  logic [ENTW-1:0] RW0_rdata_3
);

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [1:0]      rr_q, rr_d;
    logic            lookup_q, lookup_d;
    logic [TAGW-1:0] lk_tag_q, lk_tag_d;

    logic [ENTW-1:0]  rdata [NWAYS];
    logic [NWAYS-1:0] way_valid;
    logic [NWAYS-1:0] way_match;
    logic [NWAYS-1:0] wmask;
    logic [ENTW-1:0]  wdata;
    logic [1:0]       victim_way;
    logic             en_raw;
    logic             sweeping;
    logic             accept;

    assign rdata[0] = RW0_rdata_0;
    assign rdata[1] = RW0_rdata_1;
    assign rdata[2] = RW0_rdata_2;
    assign rdata[3] = RW0_rdata_3;

    // Outputs are forced idle while reset is held, not just after the edge.
    assign sweeping   = (state_q != ST_IDLE);
    assign req_ready  = reset_n && !sweeping && !flush_req;
    assign accept     = req_valid && req_ready;
    assign flush_busy = !reset_n || sweeping;
    assign resp_valid = reset_n && lookup_q;
    assign RW0_en     = reset_n && en_raw;

    always_comb begin
        for (int w = 0; w < NWAYS; w++) begin
            way_valid[w] = rdata[w][VALID_BIT];
            way_match[w] = way_valid[w] && (rdata[w][TAGW-1:0] == lk_tag_q);
        end
    end

    tag_victim_sel u_victim_sel (
        .valid      (way_valid),
        .rr_cnt     (rr_q),
        .victim_way (victim_way)
    );

    // Multiple matches are a protocol error; the lowest matching way wins.
    always_comb begin
        resp_hit_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                resp_hit_way    = '0;
                resp_hit_way[w] = 1'b1;
            end
        end
    end

    assign resp_hit          = |way_match;
    assign resp_victim_way   = victim_way;
    assign resp_victim_valid = rdata[victim_way][VALID_BIT];
    assign resp_victim_dirty = rdata[victim_way][DIRTY_BIT];
    assign resp_victim_tag   = rdata[victim_way][TAGW-1:0];

    assign RW0_wdata_0 = wdata;
    assign RW0_wdata_1 = wdata;
    assign RW0_wdata_2 = wdata;
    assign RW0_wdata_3 = wdata;
    assign RW0_wmask_0 = wmask[0];
    assign RW0_wmask_1 = wmask[1];
    assign RW0_wmask_2 = wmask[2];
    assign RW0_wmask_3 = wmask[3];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        lookup_d  = 1'b0;
        lk_tag_d  = lk_tag_q;
        en_raw    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = req_idx;
        wmask     = '0;
        wdata     = '0;

        if (resp_valid && !resp_hit && (&way_valid)) begin
            rr_d = rr_q + 2'd1;
        end

        case (state_q)
            ST_INIT, ST_FLUSH: begin
                en_raw    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = cnt_q;
                wmask     = '1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == IDXW'(NSETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (accept) begin
                    case (req_cmd)
                        CMD_LOOKUP: begin
                            en_raw   = 1'b1;
                            lookup_d = 1'b1;
                            lk_tag_d = req_tag;
                        end
                        CMD_WRITE: begin
                            en_raw    = 1'b1;
                            RW0_wmode = 1'b1;
                            wmask     = req_way_mask;
                            wdata     = make_entry(req_dirty, req_tag);
                        end
                        CMD_INVAL: begin
                            en_raw    = 1'b1;
                            RW0_wmode = 1'b1;
                            wmask     = '1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            rr_q     <= '0;
            lookup_q <= 1'b0;
            lk_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            lookup_q <= lookup_d;
            lk_tag_q <= lk_tag_d;
        end
    end

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Self-checking bench for tag_array_ctrl: SRAM model, per-set reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tag_array_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, req_valid, req_dirty, flush_req;
    logic [1:0]  req_cmd;
    logic [5:0]  req_idx;
    logic [19:0] req_tag;
    logic [3:0]  req_way_mask;

    logic        req_ready, resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty, flush_busy;
    logic [3:0]  resp_hit_way;
    logic [1:0]  resp_victim_way;
    logic [19:0] resp_victim_tag;
    logic [5:0]  RW0_addr;
    logic        RW0_en, RW0_wmode;
    logic [21:0] RW0_wdata_0, RW0_wdata_1, RW0_wdata_2, RW0_wdata_3;
    logic        RW0_wmask_0, RW0_wmask_1, RW0_wmask_2, RW0_wmask_3;
    logic [21:0] RW0_rdata_0, RW0_rdata_1, RW0_rdata_2, RW0_rdata_3;

    int checks = 0;
    int errors = 0;

    tag_array_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_idx(req_idx), .req_tag(req_tag), .req_dirty(req_dirty), .req_way_mask(req_way_mask),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_hit_way(resp_hit_way),
        .resp_victim_way(resp_victim_way), .resp_victim_valid(resp_victim_valid),
        .resp_victim_dirty(resp_victim_dirty), .resp_victim_tag(resp_victim_tag),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wdata_0(RW0_wdata_0), .RW0_wdata_1(RW0_wdata_1),
        .RW0_wdata_2(RW0_wdata_2), .RW0_wdata_3(RW0_wdata_3),
        .RW0_wmask_0(RW0_wmask_0), .RW0_wmask_1(RW0_wmask_1),
        .RW0_wmask_2(RW0_wmask_2), .RW0_wmask_3(RW0_wmask_3),
        .RW0_rdata_0(RW0_rdata_0), .RW0_rdata_1(RW0_rdata_1),
        .RW0_rdata_2(RW0_rdata_2), .RW0_rdata_3(RW0_rdata_3)
    );

    // Single-port SRAM with per-way write mask and registered read data.
    logic [21:0] sram [64][4];
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                if (RW0_wmask_0) sram[RW0_addr][0] <= RW0_wdata_0;
                if (RW0_wmask_1) sram[RW0_addr][1] <= RW0_wdata_1;
                if (RW0_wmask_2) sram[RW0_addr][2] <= RW0_wdata_2;
                if (RW0_wmask_3) sram[RW0_addr][3] <= RW0_wdata_3;
            end else begin
                RW0_rdata_0 <= sram[RW0_addr][0];
                RW0_rdata_1 <= sram[RW0_addr][1];
                RW0_rdata_2 <= sram[RW0_addr][2];
                RW0_rdata_3 <= sram[RW0_addr][3];
            end
        end
    end

    // Reference model: cache contents per set/way, sweep progress, pending lookup snapshot.
    bit          ref_v [64][4];
    bit          ref_d [64][4];
    bit [19:0]   ref_t [64][4];
    int          sweep_left = 64;
    bit          pend = 1'b0;
    bit          snap_v [4];
    bit          snap_d [4];
    bit [19:0]   snap_t [4];
    bit [19:0]   snap_tag;
    int          rr = 0;

    logic        exp_ready, exp_busy, exp_en, exp_wmode, exp_rvalid, exp_hit;
    logic        exp_vvalid, exp_vdirty;
    logic [5:0]  exp_addr;
    logic [3:0]  exp_wmask, exp_hit_way;
    logic [1:0]  exp_vway;
    logic [19:0] exp_vtag;
    logic [21:0] exp_wdata;
    bit          check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs, derive expectations, advance the model at the edge.
    task automatic applyStimulus(input logic rn, input logic v, input logic [1:0] cmd,
                                 input logic [5:0] idx, input logic [19:0] tag,
                                 input logic dirty, input logic [3:0] mask, input logic fl);
        bit acc, allv;
        int sp;
        reset_n = rn; req_valid = v; req_cmd = cmd; req_idx = idx;
        req_tag = tag; req_dirty = dirty; req_way_mask = mask; flush_req = fl;

        sp        = 64 - sweep_left;
        exp_busy  = !rn || (sweep_left > 0);
        exp_ready = rn && (sweep_left == 0) && !fl;
        acc       = exp_ready && v;
        exp_en    = rn && ((sweep_left > 0) || (acc && cmd != 2'd3));
        if (sweep_left > 0) begin
            exp_addr = 6'(sp); exp_wmode = 1'b1; exp_wmask = 4'hF; exp_wdata = '0;
        end else begin
            exp_addr  = idx;
            exp_wmode = (cmd != 2'd0);
            exp_wmask = (cmd == 2'd1) ? mask : 4'hF;
            exp_wdata = (cmd == 2'd1) ? {1'b1, dirty, tag} : 22'h0;
        end

        exp_rvalid  = rn && pend;
        exp_hit     = 1'b0;
        exp_hit_way = 4'h0;
        allv        = 1'b1;
        for (int w = 0; w < 4; w++) begin
            if (!exp_hit && snap_v[w] && snap_t[w] == snap_tag) begin
                exp_hit = 1'b1;
                exp_hit_way = 4'(1 << w);
            end
            allv = allv && snap_v[w];
        end
        exp_vway = 2'(rr);
        for (int w = 0; w < 4; w++) begin
            if (!snap_v[w]) begin
                exp_vway = 2'(w);
                break;
            end
        end
        exp_vvalid = snap_v[exp_vway];
        exp_vdirty = snap_d[exp_vway];
        exp_vtag   = snap_t[exp_vway];
        check_en   = 1'b1;

        @(posedge clock);
        if (!rn) begin
            sweep_left = 64; pend = 1'b0; rr = 0;
        end else begin
            if (pend && !exp_hit && allv) rr = (rr + 1) % 4;
            pend = 1'b0;
            if (sweep_left > 0) begin
                for (int w = 0; w < 4; w++) begin
                    ref_v[sp][w] = 1'b0; ref_d[sp][w] = 1'b0; ref_t[sp][w] = '0;
                end
                sweep_left--;
            end else if (fl) begin
                sweep_left = 64;
            end else if (acc) begin
                case (cmd)
                    2'd0: begin
                        pend = 1'b1; snap_tag = tag;
                        for (int w = 0; w < 4; w++) begin
                            snap_v[w] = ref_v[idx][w]; snap_d[w] = ref_d[idx][w]; snap_t[w] = ref_t[idx][w];
                        end
                    end
                    2'd1: for (int w = 0; w < 4; w++) begin
                        if (mask[w]) begin
                            ref_v[idx][w] = 1'b1; ref_d[idx][w] = dirty; ref_t[idx][w] = tag;
                        end
                    end
                    2'd2: for (int w = 0; w < 4; w++) begin
                        ref_v[idx][w] = 1'b0; ref_d[idx][w] = 1'b0; ref_t[idx][w] = '0;
                    end
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic idleCycles(input int n, input logic rn);
        for (int i = 0; i < n; i++) applyStimulus(rn, 1'b0, 2'd0, 6'd0, 20'd0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic doWrite(input logic [5:0] idx, input logic [19:0] tag, input logic dirty, input logic [3:0] mask);
        applyStimulus(1'b1, 1'b1, 2'd1, idx, tag, dirty, mask, 1'b0);
    endtask

    task automatic doLookup(input logic [5:0] idx, input logic [19:0] tag);
        applyStimulus(1'b1, 1'b1, 2'd0, idx, tag, 1'b0, 4'h0, 1'b0);
    endtask

    // Every-cycle comparison of DUT outputs against the model expectations.
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("flush_busy", 32'(flush_busy), 32'(exp_busy));
            checkOutput("RW0_en", 32'(RW0_en), 32'(exp_en));
            checkOutput("resp_valid", 32'(resp_valid), 32'(exp_rvalid));
            if (exp_en) begin
                checkOutput("RW0_addr", 32'(RW0_addr), 32'(exp_addr));
                checkOutput("RW0_wmode", 32'(RW0_wmode), 32'(exp_wmode));
                if (exp_wmode) begin
                    checkOutput("RW0_wmask", 32'({RW0_wmask_3, RW0_wmask_2, RW0_wmask_1, RW0_wmask_0}), 32'(exp_wmask));
                    checkOutput("RW0_wdata_0", 32'(RW0_wdata_0), 32'(exp_wdata));
                    checkOutput("RW0_wdata_1", 32'(RW0_wdata_1), 32'(exp_wdata));
                    checkOutput("RW0_wdata_2", 32'(RW0_wdata_2), 32'(exp_wdata));
                    checkOutput("RW0_wdata_3", 32'(RW0_wdata_3), 32'(exp_wdata));
                end
            end
            if (exp_rvalid) begin
                checkOutput("resp_hit", 32'(resp_hit), 32'(exp_hit));
                checkOutput("resp_hit_way", 32'(resp_hit_way), 32'(exp_hit_way));
                checkOutput("resp_victim_way", 32'(resp_victim_way), 32'(exp_vway));
                checkOutput("resp_victim_valid", 32'(resp_victim_valid), 32'(exp_vvalid));
                checkOutput("resp_victim_dirty", 32'(resp_victim_dirty), 32'(exp_vdirty));
                checkOutput("resp_victim_tag", 32'(resp_victim_tag), 32'(exp_vtag));
            end
        end
    end

    initial begin
        logic       r_rn, r_v, r_dirty, r_fl;
        logic [1:0] r_cmd;
        logic [5:0] r_idx;
        logic [19:0] r_tag;
        logic [3:0] r_mask;

        reset_n = 1'b0; req_valid = 1'b0; req_cmd = 2'd0; req_idx = '0;
        req_tag = '0; req_dirty = 1'b0; req_way_mask = '0; flush_req = 1'b0;
        @(posedge clock);
        #1;

        // Reset and initial sweep timing
        idleCycles(3, 1'b0);
        checkOutput("rst_flush_busy", 32'(flush_busy), 32'd1);
        checkOutput("rst_RW0_en", 32'(RW0_en), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        idleCycles(63, 1'b1);
        checkOutput("init63_busy", 32'(flush_busy), 32'd1);
        checkOutput("init63_addr", 32'(RW0_addr), 32'd63);
        idleCycles(1, 1'b1);
        checkOutput("init64_ready", 32'(req_ready), 32'd1);
        checkOutput("init64_busy", 32'(flush_busy), 32'd0);

        // Masked write then hit
        doWrite(6'd5, 20'h12345, 1'b0, 4'b0100);
        doLookup(6'd5, 20'h12345);
        checkOutput("hit5_valid", 32'(resp_valid), 32'd1);
        checkOutput("hit5_hit", 32'(resp_hit), 32'd1);
        checkOutput("hit5_way", 32'(resp_hit_way), 32'h4);
        checkOutput("hit5_victim", 32'(resp_victim_way), 32'd0);

        // Full set: round-robin victims 0,1,2,3,0
        doWrite(6'd9, 20'd1, 1'b0, 4'b0001);
        doWrite(6'd9, 20'd2, 1'b0, 4'b0010);
        doWrite(6'd9, 20'd3, 1'b0, 4'b0100);
        doWrite(6'd9, 20'd4, 1'b0, 4'b1000);
        for (int k = 0; k < 5; k++) begin
            doLookup(6'd9, 20'd7);
            checkOutput("rr_hit", 32'(resp_hit), 32'd0);
            checkOutput("rr_victim_way", 32'(resp_victim_way), 32'(k % 4));
            checkOutput("rr_victim_valid", 32'(resp_victim_valid), 32'd1);
            checkOutput("rr_victim_tag", 32'(resp_victim_tag), 32'(k % 4 + 1));
        end

        // Dirty victim selected by round-robin position 2
        doWrite(6'd3, 20'h30, 1'b1, 4'b0100);
        doWrite(6'd3, 20'h31, 1'b0, 4'b1011);
        doLookup(6'd9, 20'd7);
        doLookup(6'd3, 20'h99);
        checkOutput("dirty_victim_way", 32'(resp_victim_way), 32'd2);
        checkOutput("dirty_victim_dirty", 32'(resp_victim_dirty), 32'd1);
        checkOutput("dirty_victim_tag", 32'(resp_victim_tag), 32'h30);

        // Flush beats a simultaneous request; mid-sweep flush pulse is ignored
        applyStimulus(1'b1, 1'b1, 2'd0, 6'd5, 20'h12345, 1'b0, 4'h0, 1'b1);
        checkOutput("flush_busy_start", 32'(flush_busy), 32'd1);
        checkOutput("flush_resp_valid", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd0, 6'd0, 20'd0, 1'b0, 4'h0, (i == 10));
        end
        checkOutput("flush_done_busy", 32'(flush_busy), 32'd0);
        doLookup(6'd5, 20'h12345);
        checkOutput("flush_miss", 32'(resp_hit), 32'd0);

        // Reset in the middle of the initial sweep
        idleCycles(2, 1'b0);
        idleCycles(30, 1'b1);
        checkOutput("midinit_addr", 32'(RW0_addr), 32'd30);
        idleCycles(1, 1'b0);
        idleCycles(63, 1'b1);
        checkOutput("reinit63_busy", 32'(flush_busy), 32'd1);
        idleCycles(1, 1'b1);
        checkOutput("reinit64_ready", 32'(req_ready), 32'd1);

        // Randomized traffic over a few sets and tags to produce hits and full sets
        for (int i = 0; i < 3000; i++) begin
            r_rn    = ($urandom_range(0, 599) != 0);
            r_v     = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: r_cmd = 2'd0;
                5, 6, 7:       r_cmd = 2'd1;
                8:             r_cmd = 2'd2;
                default:       r_cmd = 2'd3;
            endcase
            r_idx   = 6'($urandom_range(0, 7));
            r_tag   = 20'($urandom_range(0, 5));
            r_dirty = 1'($urandom_range(0, 1));
            r_mask  = 4'($urandom_range(0, 15));
            r_fl    = ($urandom_range(0, 249) == 0);
            applyStimulus(r_rn, r_v, r_cmd, r_idx, r_tag, r_dirty, r_mask, r_fl);
        end
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
